// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle instruction sequencer. It accepts one opcode per instruction
// from the fetch stage, walks it through DECODE / EXEC / MEM / WB, and drives
// the register file, ALU and data memory strobes. It also counts retired
// instructions.
//
// Handshakes:
//   instr_valid/instr_ready : the opcode transfers on a rising edge where both
//                             are high. instr_ready is high only in IDLE (and
//                             never while rst=1). While instr_ready is low,
//                             instr_valid and opcode are ignored.
//   mem_read|mem_write/ack  : the request is held high in every MEM cycle.
//                             mem_ack is sampled in each MEM cycle. If it is
//                             missing for MEM_TIMEOUT cycles, the access is
//                             abandoned and timeout_err pulses for one cycle.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an illegal opcode parks the unit in TRAP until trap_clear.
//   undefined : an illegal opcode is dropped as a NOP. trap is tied to 0 and
//               trap_clear is ignored.
//
// Ports:
//   clk, rst (sync, active-high)
//   instr_valid, instr_ready, opcode[OPCODE_W]  - instruction handshake
//   zero_flag                                   - ALU zero flag, used by BRZ
//   mem_ack                                     - data memory completion
//   reg_write, mem_read, mem_write              - datapath strobes
//   branch_taken                                - branch redirect pulse
//   alu_op[2]                                   - 00 ADD, 01 SUB, 10 AND, 11 OR
//   busy, timeout_err, trap, trap_clear         - status / trap control
//   retired_count[CNT_W]                        - retired instruction count
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                mem_ack,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch_taken,
    output logic [1:0]          alu_op,
    output logic                busy,
    output logic                timeout_err,
    output logic                trap,
    input  logic                trap_clear,
    output logic [CNT_W-1:0]    retired_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // The wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [OPCODE_W-1:0] OP_BRZ   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(6);

    state_t              state;
    logic [OPCODE_W-1:0] op_q;
    logic [WAIT_W-1:0]   wait_cnt;

    // Classify the latched opcode. Any bit above bit 2 makes the opcode
    // illegal. The shift form also works when OPCODE_W is exactly 3.
    logic op_hi_set;
    logic is_alu;
    logic is_brz;
    logic is_load;
    logic is_store;

    assign op_hi_set = (op_q >> 3) != '0;
    assign is_alu    = !op_hi_set && !op_q[2];
    assign is_brz    = (op_q == OP_BRZ);
    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);

`ifndef ILLEGAL_TRAP_EN
    logic unused_trap_clear;
    assign unused_trap_clear = trap_clear;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            op_q          <= '0;
            wait_cnt      <= '0;
            retired_count <= '0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= opcode;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_alu || is_brz) begin
                        state <= S_EXEC;
                    end else if (is_load || is_store) begin
                        wait_cnt <= '0;
                        state    <= S_MEM;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state <= S_TRAP;
`else
                        state <= S_IDLE;
`endif
                    end
                end
                S_EXEC: begin
                    if (is_brz) begin
                        // A branch retires whether or not it is taken.
                        state         <= S_IDLE;
                        retired_count <= retired_count + CNT_W'(1);
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    // An ack in the last allowed cycle still completes.
                    if (mem_ack) begin
                        if (is_load) begin
                            state <= S_WB;
                        end else begin
                            state         <= S_IDLE;
                            retired_count <= retired_count + CNT_W'(1);
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    state         <= S_IDLE;
                    retired_count <= retired_count + CNT_W'(1);
                end
                S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                    if (trap_clear) begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register and op_q. The only input
    // that reaches an output combinationally is zero_flag, into branch_taken.
    // instr_ready is also gated by rst.
    always_comb begin
        instr_ready  = 1'b0;
        busy         = 1'b1;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        branch_taken = 1'b0;
        alu_op       = 2'b00;
        trap         = 1'b0;
        case (state)
            S_IDLE: begin
                busy        = 1'b0;
                instr_ready = !rst;
            end
            S_EXEC: begin
                if (is_alu) alu_op = op_q[1:0];
                if (is_brz) branch_taken = zero_flag;
            end
            S_MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
            end
            S_WB: begin
                reg_write = 1'b1;
                // A load write-back leaves alu_op at 00.
                if (is_alu) alu_op = op_q[1:0];
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                trap = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Bench for multicycle_control_unit. It runs directed and random
// instructions. For each instruction, a reference model builds the expected
// per-cycle output trace from the instruction-level timing rules:
//   ALU   : DECODE, EXEC, WB
//   BRZ   : DECODE, EXEC
//   LOAD  : DECODE, k x MEM, WB
//   STORE : DECODE, k x MEM
// The bench then compares both instances against that trace.
// A second instance with CNT_W=2 shares every input. Its narrow
// retired_count must wrap.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int OPCODE_W    = 4;
    localparam int MEM_TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic                instr_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                zero_flag;
    logic                mem_ack;
    logic                trap_clear;

    logic        instr_ready,  reg_write,  mem_read,  mem_write,  branch_taken;
    logic        busy,  timeout_err,  trap;
    logic [1:0]  alu_op;
    logic [15:0] retired_count;

    logic        instr_ready2, reg_write2, mem_read2, mem_write2, branch_taken2;
    logic        busy2, timeout_err2, trap2;
    logic [1:0]  alu_op2;
    logic [1:0]  retired_count2;

    int tests = 0;
    int fails = 0;

    logic [9:0]  exp_q[$];
    logic [15:0] exp_count = '0;
    logic        exp_to    = 1'b0;

    multicycle_control_unit #(
        .OPCODE_W(OPCODE_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .zero_flag(zero_flag), .mem_ack(mem_ack),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch_taken(branch_taken), .alu_op(alu_op), .busy(busy),
        .timeout_err(timeout_err), .trap(trap), .trap_clear(trap_clear),
        .retired_count(retired_count)
    );

    multicycle_control_unit #(
        .OPCODE_W(OPCODE_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(2)
    ) u_dut_wrap (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready2),
        .opcode(opcode), .zero_flag(zero_flag), .mem_ack(mem_ack),
        .reg_write(reg_write2), .mem_read(mem_read2), .mem_write(mem_write2),
        .branch_taken(branch_taken2), .alu_op(alu_op2), .busy(busy2),
        .timeout_err(timeout_err2), .trap(trap2), .trap_clear(trap_clear),
        .retired_count(retired_count2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output vector: {ready, busy, reg_write, mem_read, mem_write,
    //                 branch_taken, alu_op[1:0], timeout_err, trap}
    function automatic logic [9:0] mk(input logic r, input logic b, input logic rw,
                                      input logic mr, input logic mw, input logic bt,
                                      input logic [1:0] alu, input logic to, input logic tr);
        return {r, b, rw, mr, mw, bt, alu, to, tr};
    endfunction

    function automatic logic [9:0] obs1();
        return {instr_ready, busy, reg_write, mem_read, mem_write, branch_taken,
                alu_op, timeout_err, trap};
    endfunction

    function automatic logic [9:0] obs2();
        return {instr_ready2, busy2, reg_write2, mem_read2, mem_write2, branch_taken2,
                alu_op2, timeout_err2, trap2};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst         = 1'b1;
        instr_valid = 1'b1;
        opcode      = '0;
        zero_flag   = 1'b0;
        mem_ack     = 1'b0;
        trap_clear  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", 32'(obs1()), 32'(mk(0,0,0,0,0,0,2'b00,0,0)));
        check("reset_count", 32'(retired_count), 32'd0);
        check("reset_outputs_w", 32'(obs2()), 32'(mk(0,0,0,0,0,0,2'b00,0,0)));
        instr_valid = 1'b0;
        rst         = 1'b0;
        exp_count   = '0;
        exp_to      = 1'b0;
    endtask

    // Issue one instruction in the current IDLE cycle and follow it until it
    // is back in IDLE.
    //   ack_at : MEM cycle (1-based) that sees mem_ack=1; 0 means never.
    //   zf     : zero_flag driven during the EXEC cycle.
    //   hold   : number of TRAP cycles before trap_clear (macro builds only).
    task automatic run_instr(input logic [OPCODE_W-1:0] op, input int ack_at,
                             input logic zf, input int hold);
        logic is_alu, is_brz, is_ld, is_st, is_mem, retire, to_next;
        int   n_mem;
        int   len;
        is_alu  = (op < 4);
        is_brz  = (op == 4);
        is_ld   = (op == 5);
        is_st   = (op == 6);
        is_mem  = is_ld || is_st;
        retire  = 1'b0;
        to_next = 1'b0;
        n_mem   = (ack_at == 0) ? MEM_TIMEOUT : ack_at;

        // Reference trace, one entry per cycle after the accept edge.
        exp_q.delete();
        exp_q.push_back(mk(0,1,0,0,0,0,2'b00,0,0));
        if (is_alu) begin
            exp_q.push_back(mk(0,1,0,0,0,0,op[1:0],0,0));
            exp_q.push_back(mk(0,1,1,0,0,0,op[1:0],0,0));
            retire = 1'b1;
        end else if (is_brz) begin
            exp_q.push_back(mk(0,1,0,0,0,zf,2'b00,0,0));
            retire = 1'b1;
        end else if (is_mem) begin
            for (int k = 0; k < n_mem; k++)
                exp_q.push_back(mk(0,1,0,is_ld,is_st,0,2'b00,0,0));
            if (ack_at == 0) begin
                to_next = 1'b1;
            end else begin
                if (is_ld) exp_q.push_back(mk(0,1,1,0,0,0,2'b00,0,0));
                retire = 1'b1;
            end
        end else begin
`ifdef ILLEGAL_TRAP_EN
            for (int k = 0; k < hold; k++)
                exp_q.push_back(mk(0,1,0,0,0,0,2'b00,0,1));
`endif
        end
        len = exp_q.size();

        // Idle cycle: offer the opcode and check the idle state left behind
        // by the previous instruction.
        @(negedge clk);
        instr_valid = 1'b1;
        opcode      = op;
        zero_flag   = 1'($urandom_range(0, 1));
        mem_ack     = 1'($urandom_range(0, 1));
        trap_clear  = 1'b0;
        #1;
        check("idle", 32'(obs1()), 32'(mk(1,0,0,0,0,0,2'b00,exp_to,0)));
        check("count", 32'(retired_count), 32'(exp_count));
        check("idle_w", 32'(obs2()), 32'(mk(1,0,0,0,0,0,2'b00,exp_to,0)));
        check("count_wrap", 32'(retired_count2), 32'(exp_count[1:0]));

        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            // Busy cycles: random offers must not be taken.
            instr_valid = 1'($urandom_range(0, 1));
            opcode      = OPCODE_W'($urandom_range(0, 15));
            zero_flag   = (c == 2) ? zf : 1'($urandom_range(0, 1));
            if (is_mem && c >= 2 && c <= n_mem + 1)
                mem_ack = (c - 1 == ack_at);
            else
                mem_ack = 1'($urandom_range(0, 1));
            trap_clear = (c == len && !is_alu && !is_brz && !is_mem) ? 1'b1 : 1'b0;
            #1;
            check($sformatf("op%0d_c%0d", op, c), 32'(obs1()), 32'(exp_q[c-1]));
            check($sformatf("op%0d_c%0d_w", op, c), 32'(obs2()), 32'(exp_q[c-1]));
        end
        trap_clear = 1'b0;
        if (retire) exp_count = exp_count + 16'd1;
        exp_to = to_next;
    endtask

    // Reset arriving in the middle of a LOAD that is waiting for mem_ack.
    task automatic reset_mid_load();
        @(negedge clk);
        instr_valid = 1'b1;
        opcode      = OPCODE_W'(5);
        mem_ack     = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_load_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_outputs", 32'(obs1()), 32'(mk(0,0,0,0,0,0,2'b00,0,0)));
        check("mid_rst_count", 32'(retired_count), 32'd0);
        check("mid_rst_count_w", 32'(retired_count2), 32'd0);
        rst       = 1'b0;
        exp_count = '0;
        exp_to    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        run_instr(4'd0, 0, 1'b0, 0);          // ADD
        run_instr(4'd4, 0, 1'b1, 0);          // BRZ taken
        run_instr(4'd4, 0, 1'b0, 0);          // BRZ not taken
        run_instr(4'd5, 3, 1'b0, 0);          // LOAD, ack in 3rd MEM cycle
        run_instr(4'd6, 1, 1'b0, 0);          // STORE, immediate ack
        run_instr(4'd6, 0, 1'b0, 0);          // STORE, timeout
        run_instr(4'd5, MEM_TIMEOUT, 1'b0, 0);// ack on the last allowed cycle
        run_instr(4'hF, 0, 1'b0, 3);          // illegal
        run_instr(4'd7, 0, 1'b0, 1);          // illegal (low bits)
        for (int i = 0; i < 4; i++)
            run_instr(OPCODE_W'(i), 0, 1'b0, 0);  // ADD/SUB/AND/OR, wraps narrow count

        for (int i = 0; i < 60; i++) begin
            logic [OPCODE_W-1:0] op;
            int ack_at;
            op     = OPCODE_W'($urandom_range(0, 15));
            ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            run_instr(op, ack_at, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end

        reset_mid_load();
        run_instr(4'd1, 0, 1'b0, 0);          // SUB after reset
        run_instr(4'd2, 0, 1'b0, 0);

        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        check("final_count", 32'(retired_count), 32'(exp_count));
        check("final_idle", 32'(obs1()), 32'(mk(1,0,0,0,0,0,2'b00,exp_to,0)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
